// File: rtl/pipe_ctrl_pkg.sv
// Package for the pipelined MIPS control unit.
// Holds opcode values, ALUop codes, control-word bit indices, forwarding
// select codes and the eight legal decode words. No ports.
package pipe_ctrl_pkg;

  localparam int CTRL_BITS = 11;

  // Opcode values (compared against the full opcode width in the decoder)
  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 6;
  localparam int OP_SLT = 7;
  localparam int OP_LW  = 8;
  localparam int OP_SW  = 10;
  localparam int OP_BNE = 14;

  // ALUop codes; 11x unused
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ARITH = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LT   = 3'b100;
  localparam logic [2:0] ALU_BNE  = 3'b101;

  // Control-word bit positions
  localparam int CB_SPARE     = 10;
  localparam int CB_REG_WRITE = 9;
  localparam int CB_ALU_SRC   = 8;
  localparam int CB_MEM_WRITE = 7;
  localparam int CB_ALUOP_HI  = 6;
  localparam int CB_ALUOP_LO  = 4;
  localparam int CB_MEM_READ  = 3;
  localparam int CB_MEM_TO_REG = 2;
  localparam int CB_BRANCH    = 1;
  localparam int CB_REG_DST   = 0;

  // Operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef logic [CTRL_BITS-1:0] ctrl_word_t;

  // Decode words: spare | RegWrite ALUSrc | MemWrite ALUop | MemRead MemToReg Branch RegDst
  localparam ctrl_word_t CTRL_AND = 11'b010_0010_0001;
  localparam ctrl_word_t CTRL_OR  = 11'b010_0011_0001;
  localparam ctrl_word_t CTRL_ADD = 11'b010_0000_0001;
  localparam ctrl_word_t CTRL_SUB = 11'b010_0001_0001;
  localparam ctrl_word_t CTRL_SLT = 11'b010_0100_0001;
  localparam ctrl_word_t CTRL_LW  = 11'b011_0001_1100;
  localparam ctrl_word_t CTRL_SW  = 11'b001_1001_0000;
  localparam ctrl_word_t CTRL_BNE = 11'b000_0101_0010;
  localparam ctrl_word_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_control_unit_hazard_fwd.sv
// hazard_fwd_unit: combinational load-use detection, BNE resolution and
// EX operand forwarding selects.
// Ports:
//   ex_mem_read, ex_branch, ex_eq  - ID/EX load/branch bits and ALU equal flag
//   ex_dst, ex_rs, ex_rt           - ID/EX register fields
//   mem_reg_write, mem_dst         - EX/MEM write-back info
//   wb_reg_write, wb_dst           - MEM/WB write-back info
//   id_rs, id_rt, id_uses_rs/rt    - ID source registers and which are read
//   load_use, branch_taken         - hazard outputs
//   fwd_a, fwd_b                   - operand selects for EX
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             ex_mem_read,
  input  logic             ex_branch,
  input  logic             ex_eq,
  input  logic [REG_W-1:0] ex_dst,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_dst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             load_use,
  output logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  // A hardwired r0 never carries a real value, so it is never a dependency.
  function automatic logic live_reg(input logic [REG_W-1:0] r);
    return !(ZERO_REG && (r == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (mem_reg_write && (mem_dst == src) && live_reg(mem_dst))
      return FWD_MEM;
    else if (wb_reg_write && (wb_dst == src) && live_reg(wb_dst))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    load_use = ex_mem_read && live_reg(ex_dst) &&
               ((id_uses_rs && (ex_dst == id_rs)) ||
                (id_uses_rt && (ex_dst == id_rt)));
    branch_taken = ex_branch && !ex_eq;
    fwd_a = fwd_sel(ex_rs);
    fwd_b = fwd_sel(ex_rt);
  end

endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined control for the 16-bit MIPS datapath.
// Decodes the ID opcode, carries the control word and destination register
// through ID/EX, EX/MEM and MEM/WB, and drives PC/IF-ID stall and flush
// controls plus EX forwarding selects.
// Ports:
//   clk, reset (sync, active-high), hold (global freeze)
//   id_opcode, id_rs, id_rt, id_rd  - instruction fields in ID
//   ex_eq                           - ALU equal flag for the EX instruction
//   ex_ctrl, mem_ctrl, wb_ctrl      - stage control words
//   ex_dst                          - ID/EX destination register
//   fwd_a, fwd_b                    - EX operand selects
//   pc_write, ifid_write, ifid_flush, pc_src, illegal_op
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int REG_W    = 3,
  parameter int CTRL_W   = 11,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                ex_eq,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [CTRL_W-1:0]   mem_ctrl,
  output logic [CTRL_W-1:0]   wb_ctrl,
  output logic [REG_W-1:0]    ex_dst,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                pc_src,
  output logic                illegal_op
);

  logic [CTRL_W-1:0] id_ctrl;
  logic              id_legal;
  logic              id_uses_rt;
  logic [REG_W-1:0]  id_dst;
  logic [REG_W-1:0]  ex_rs, ex_rt, mem_dst, wb_dst;
  logic              load_use, branch_taken, bubble;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  // Full-width compare: wider opcodes with upper bits set fall to default.
  always_comb begin
    id_ctrl    = CTRL_W'(NOP_CTRL);
    id_legal   = 1'b1;
    id_uses_rt = 1'b0;
    case (id_opcode)
      OPCODE_W'(OP_AND): begin id_ctrl = CTRL_W'(CTRL_AND); id_uses_rt = 1'b1; end
      OPCODE_W'(OP_OR):  begin id_ctrl = CTRL_W'(CTRL_OR);  id_uses_rt = 1'b1; end
      OPCODE_W'(OP_ADD): begin id_ctrl = CTRL_W'(CTRL_ADD); id_uses_rt = 1'b1; end
      OPCODE_W'(OP_SUB): begin id_ctrl = CTRL_W'(CTRL_SUB); id_uses_rt = 1'b1; end
      OPCODE_W'(OP_SLT): begin id_ctrl = CTRL_W'(CTRL_SLT); id_uses_rt = 1'b1; end
      OPCODE_W'(OP_LW):  begin id_ctrl = CTRL_W'(CTRL_LW); end
      OPCODE_W'(OP_SW):  begin id_ctrl = CTRL_W'(CTRL_SW);  id_uses_rt = 1'b1; end
      OPCODE_W'(OP_BNE): begin id_ctrl = CTRL_W'(CTRL_BNE); id_uses_rt = 1'b1; end
      default:           id_legal = 1'b0;
    endcase
    id_dst = id_ctrl[CB_REG_DST] ? id_rd : id_rt;
  end

  hazard_fwd_unit #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_hazard (
    .ex_mem_read   (ex_ctrl[CB_MEM_READ]),
    .ex_branch     (ex_ctrl[CB_BRANCH]),
    .ex_eq         (ex_eq),
    .ex_dst        (ex_dst),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_reg_write (mem_ctrl[CB_REG_WRITE]),
    .mem_dst       (mem_dst),
    .wb_reg_write  (wb_ctrl[CB_REG_WRITE]),
    .wb_dst        (wb_dst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_legal),
    .id_uses_rt    (id_uses_rt),
    .load_use      (load_use),
    .branch_taken  (branch_taken),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // Branch resolution outranks load-use: the stalled instruction is flushed anyway.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_src     = 1'b0;
    bubble     = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
    if (!reset) begin
      pc_src = branch_taken;
      fwd_a  = fwd_a_raw;
      fwd_b  = fwd_b_raw;
      if (hold) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        bubble     = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl    <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      illegal_op <= 1'b0;
      mem_ctrl   <= '0;
      mem_dst    <= '0;
      wb_ctrl    <= '0;
      wb_dst     <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_ctrl    <= '0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_dst     <= '0;
        illegal_op <= 1'b0;
      end else begin
        ex_ctrl    <= id_ctrl;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_dst     <= id_dst;
        illegal_op <= !id_legal;
      end
      mem_ctrl <= ex_ctrl;
      mem_dst  <= ex_dst;
      wb_ctrl  <= mem_ctrl;
      wb_dst   <= mem_dst;
    end
  end

endmodule
